imm_extend_pipe: RTL

Parametrised, pipelined immediate extractor and extender for the in-order core's decode path. It accepts a raw instruction word plus a format code and delivers a DATA_W-wide immediate. The immediate is sign- or zero-extended, and scaled or shifted as the format requires. A two-stage valid/ready pipeline sits between instruction fetch/decode and the register-read stage, with full backpressure support.

---
 rtl/imm_extend_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready pipeline that extracts the immediate
// field from a raw instruction word and extends it to DATA_W bits.
//   S1 holds the raw instruction and format code.
//   S2 holds the extended immediate and the error flag.
// Build option: define IMM_EXT_MOV_EN to support the MOV format (code 4).
// When it is left undefined, code 4 is reported as illegal and no MOV shift
// logic is built.
//
// Handshake: a transfer happens on the input side when in_valid && in_ready
// and on the output side when out_valid && out_ready, both on the rising
// edge of clk. A producer holds its payload stable while valid is high and
// ready is low. in_ready depends combinationally on out_ready, so a full
// pipe can accept a new item in the same cycle it emits one.

module imm_extend_pipe #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_fmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_err
);

  // Format codes; 5..7 (and 4 without MOV support) are illegal.
  localparam logic [2:0] FMT_B   = 3'd0;
  localparam logic [2:0] FMT_CB  = 3'd1;
  localparam logic [2:0] FMT_D   = 3'd2;
  localparam logic [2:0] FMT_I   = 3'd3;
`ifdef IMM_EXT_MOV_EN
  localparam logic [2:0] FMT_MOV = 3'd4;
`endif

  // Stage 1: raw instruction and format.
  logic               s1_valid_q, s1_valid_d;
  logic [INSTR_W-1:0] s1_instr_q, s1_instr_d;
  logic [2:0]         s1_fmt_q,   s1_fmt_d;

  // Stage 2: extended result, which is also the output register.
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_imm_q,   out_imm_d;
  logic               out_err_q,   out_err_d;

  // Handshake helpers.
  logic               s2_load;
  logic               in_fire;

  // Extension results for the item sitting in S1.
  logic [DATA_W-1:0]  b_ext;
  logic [DATA_W-1:0]  cb_ext;
  logic [DATA_W-1:0]  d_ext;
  logic [DATA_W-1:0]  i_ext;
  logic [DATA_W-1:0]  calc_imm;
  logic               calc_err;

`ifdef IMM_EXT_MOV_EN
  logic [1:0]         mov_hw;
  logic [5:0]         mov_shamt;
  logic               mov_ovf;
  logic [DATA_W-1:0]  mov_ext;
`endif

  // Upper opcode bits never feed any immediate field.
  logic               unused_instr_bits;
  assign unused_instr_bits = ^s1_instr_q[INSTR_W-1:26];

  // Sign/zero extend each candidate field of the S1 instruction.
  always_comb begin
    b_ext  = {{(DATA_W-26){s1_instr_q[25]}}, s1_instr_q[25:0]};
    cb_ext = {{(DATA_W-19){s1_instr_q[23]}}, s1_instr_q[23:5]};
    d_ext  = {{(DATA_W-9){s1_instr_q[20]}},  s1_instr_q[20:12]};
    i_ext  = {{(DATA_W-12){1'b0}},           s1_instr_q[21:10]};
  end

`ifdef IMM_EXT_MOV_EN
  // MOV: zero-extend the 16-bit field and place it in halfword hw; a
  // halfword that does not fit inside DATA_W is reported as an error.
  always_comb begin
    mov_hw    = s1_instr_q[22:21];
    mov_shamt = {mov_hw, 4'b0000};
    mov_ovf   = (int'(mov_shamt) + 16) > DATA_W;
    mov_ext   = {{(DATA_W-16){1'b0}}, s1_instr_q[20:5]};
  end
`endif

  // Select the result by format; errors always carry a zero immediate.
  always_comb begin
    calc_imm = '0;
    calc_err = 1'b0;
    case (s1_fmt_q)
      FMT_B:   calc_imm = b_ext << 2;
      FMT_CB:  calc_imm = cb_ext << 2;
      FMT_D:   calc_imm = d_ext;
      FMT_I:   calc_imm = i_ext;
`ifdef IMM_EXT_MOV_EN
      FMT_MOV: begin
        if (mov_ovf) begin
          calc_err = 1'b1;
        end else begin
          calc_imm = mov_ext << mov_shamt;
        end
      end
`endif
      default: calc_err = 1'b1;
    endcase
  end

  // Pipeline control: S2 refills when empty or draining, S1 refills when
  // empty or moving into S2; an error item flows like any other.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    in_fire  = in_valid && in_ready;

    s1_valid_d = s1_valid_q && !s2_load;
    s1_instr_d = s1_instr_q;
    s1_fmt_d   = s1_fmt_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_instr_d = in_instr;
      s1_fmt_d   = in_fmt;
    end

    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_err_d   = out_err_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_imm_d = calc_imm;
        out_err_d = calc_err;
      end
    end
  end

  // State registers; reset empties both stages and clears the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s1_fmt_q    <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s1_fmt_q    <= s1_fmt_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_err   = out_err_q;

endmodule
